// File: rtl/lap_stopwatch_core.sv
// lap_stopwatch_core: prescaled hundredths stopwatch with an 8-digit packed-BCD
// time (HH:MM:SS.cc), lap hold, stopped clear, preset load and a configurable hour wrap.
// Optional build macro COUNTDOWN_EN adds count-down mode with a done pulse at zero.
// start/lap are debounced level inputs; only their rising edges act.
// load is a single-cycle strobe with no ready: it is taken only while stopped and dropped otherwise.
module lap_stopwatch_core #(
   parameter int CLK_HZ    = 100000000,
   parameter int TICK_HZ   = 100,
   parameter int MAX_HOURS = 99
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        lap,
   input  logic        mode_down,
   input  logic        load,
   input  logic [31:0] preset,
   output logic [31:0] time_bcd,
   output logic [31:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        tick,
   output logic        done
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [31:0]   time_q, time_d;
   logic [31:0]   lap_reg_q, lap_reg_d;
   logic          lap_active_q, lap_active_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;
   logic          start_prev, lap_prev;
   logic          start_edge, lap_edge;
   logic          presc_wrap;
   logic          unused_mode;

   // Binary value of a two-digit BCD hour field.
   function automatic int hour_val(input logic [7:0] h);
      return int'(h[7:4]) * 10 + int'(h[3:0]);
   endfunction

   // Clamp each preset digit into its legal range (tens of SS/MM to 5, others to 9).
   function automatic logic [31:0] bcd_clamp(input logic [31:0] p);
      logic [31:0] r;
      r = p;
      for (int i = 0; i < 8; i++) begin
         if ((i == 3) || (i == 5)) begin
            if (r[i*4 +: 4] > 4'd5) r[i*4 +: 4] = 4'd5;
         end else begin
            if (r[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
         end
      end
      return r;
   endfunction

   // Advance time by one hundredth; at the hour limit a carry wraps everything to zero.
   function automatic logic [31:0] bcd_inc(input logic [31:0] t);
      logic [31:0] r;
      logic        c;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (r[i*4 +: 4] >= (((i == 3) || (i == 5)) ? 4'd5 : 4'd9)) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      if (c) begin
         if (hour_val(r[31:24]) >= MAX_HOURS) begin
            r = 32'd0;
         end else if (r[27:24] >= 4'd9) begin
            r[27:24] = 4'd0;
            r[31:28] = r[31:28] + 4'd1;
         end else begin
            r[27:24] = r[27:24] + 4'd1;
         end
      end
      return r;
   endfunction

`ifdef COUNTDOWN_EN
   // Step time back one hundredth; zero stays zero (the caller stops there).
   function automatic logic [31:0] bcd_dec(input logic [31:0] t);
      logic [31:0] r;
      logic        b;
      r = t;
      b = (t != 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (b) begin
            if (r[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction
`endif

   assign start_edge  = start & ~start_prev;
   assign lap_edge    = lap & ~lap_prev;
   assign presc_wrap  = (presc_q == PRESC_LAST);
   assign unused_mode = mode_down;

   // Register stage for FSM state, time, lap hold, prescaler and button history.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= STOPPED;
         time_q       <= 32'd0;
         lap_reg_q    <= 32'd0;
         lap_active_q <= 1'b0;
         presc_q      <= '0;
         done_q       <= 1'b0;
         start_prev   <= start;
         lap_prev     <= lap;
      end else begin
         state_q      <= state_d;
         time_q       <= time_d;
         lap_reg_q    <= lap_reg_d;
         lap_active_q <= lap_active_d;
         presc_q      <= presc_d;
         done_q       <= done_d;
         start_prev   <= start;
         lap_prev     <= lap;
      end
   end

   // Next-state and datapath decisions; start beats lap when both edges coincide.
   always_comb begin
      state_d      = state_q;
      time_d       = time_q;
      lap_reg_d    = lap_reg_q;
      lap_active_d = lap_active_q;
      presc_d      = presc_q;
      done_d       = 1'b0;
      case (state_q)
         STOPPED: begin
            if (lap_edge && !start_edge) begin
               time_d       = 32'd0;
               lap_active_d = 1'b0;
               presc_d      = '0;
            end
            if (load) begin
               time_d  = bcd_clamp(preset);
               presc_d = '0;
            end
            if (start_edge) begin
`ifdef COUNTDOWN_EN
               if (!(mode_down && (time_d == 32'd0))) state_d = RUNNING;
`else
               state_d = RUNNING;
`endif
            end
         end
         RUNNING: begin
            if (start_edge) begin
               // Prescaler keeps its phase so a resume continues the interrupted tick.
               state_d      = STOPPED;
               lap_active_d = 1'b0;
            end else begin
               if (lap_edge) begin
                  if (!lap_active_q) begin
                     lap_reg_d    = time_q;
                     lap_active_d = 1'b1;
                  end else begin
                     lap_active_d = 1'b0;
                  end
               end
               if (presc_wrap) begin
                  presc_d = '0;
`ifdef COUNTDOWN_EN
                  if (mode_down) begin
                     time_d = bcd_dec(time_q);
                     if (time_d == 32'd0) begin
                        done_d       = 1'b1;
                        state_d      = STOPPED;
                        lap_active_d = 1'b0;
                     end
                  end else begin
                     time_d = bcd_inc(time_q);
                  end
`else
                  time_d = bcd_inc(time_q);
`endif
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
         end
         default: state_d = STOPPED;
      endcase
   end

   assign running    = (state_q == RUNNING);
   assign tick       = running && presc_wrap && !start_edge;
   assign time_bcd   = time_q;
   assign lap_active = lap_active_q;
   assign disp_bcd   = lap_active_q ? lap_reg_q : time_q;
   assign done       = done_q;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// tb_lap_stopwatch_core: directed stimulus with an expected-value queue for BCD
// results, a tick-spacing monitor and a second instance with a 12-hour limit.
module tb_lap_stopwatch_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        lap = 1'b0;
   logic        mode_down = 1'b0;
   logic        load = 1'b0;
   logic [31:0] preset = 32'd0;
   logic [31:0] time_bcd, disp_bcd, time12, disp12;
   logic        running, lap_active, tick, done;
   logic        running12, lap_active12, tick12, done12;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   int cyc_now = 0;
   int last_tick = 0;
   int mon_cnt = 0;
   int mon_bad = 0;
   logic mon_en = 1'b0;

   lap_stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_HOURS(99)) dut (
      .clk(clk), .reset(reset), .start(start), .lap(lap), .mode_down(mode_down),
      .load(load), .preset(preset), .time_bcd(time_bcd), .disp_bcd(disp_bcd),
      .running(running), .lap_active(lap_active), .tick(tick), .done(done)
   );

   lap_stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_HOURS(12)) dut12 (
      .clk(clk), .reset(reset), .start(start), .lap(lap), .mode_down(mode_down),
      .load(load), .preset(preset), .time_bcd(time12), .disp_bcd(disp12),
      .running(running12), .lap_active(lap_active12), .tick(tick12), .done(done12)
   );

   // Clock generation
   always #5 clk = ~clk;

   // Tick spacing monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (mon_en && tick) begin
         if ((mon_cnt != 0) && ((cyc_now - last_tick) != 10)) mon_bad++;
         mon_cnt++;
         last_tick = cyc_now;
      end
      cyc_now++;
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_no_expected"}, obs, ~obs);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, obs, e);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_start;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
   endtask

   task automatic press_lap;
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      cyc(1);
   endtask

   task automatic load_preset(input logic [31:0] v);
      preset = v;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   initial begin
      // Reset
      cyc(3);
      reset = 1'b0;
      cyc(1);
      exp_q.push_back(32'h0000_0000);
      sb_check("reset_time", time_bcd);
      exp_q.push_back(32'h0000_0000);
      sb_check("reset_disp", disp_bcd);
      check_eq("reset_running", {31'd0, running}, 32'd0);
      check_eq("reset_lap_active", {31'd0, lap_active}, 32'd0);
      check_eq("reset_tick", {31'd0, tick}, 32'd0);
      check_eq("reset_done", {31'd0, done}, 32'd0);

      // Ten seconds of counting with tick spacing monitored
      press_start;
      mon_en = 1'b1;
      exp_q.push_back(32'h0000_1000);
      cyc(9999);
      mon_en = 1'b0;
      sb_check("run_10s", time_bcd);
      check_eq("tick_count", mon_cnt, 1000);
      check_eq("tick_spacing_errs", mon_bad, 0);
      press_start;
      check_eq("stopped_after_run", {31'd0, running}, 32'd0);

      // Seconds/minutes carry and first-tick latency
      load_preset(32'h0000_5999);
      press_start;
      cyc(8);
      check_eq("first_tick_pulse", {31'd0, tick}, 32'd1);
      exp_q.push_back(32'h0000_5999);
      sb_check("before_carry", time_bcd);
      cyc(1);
      exp_q.push_back(32'h0001_0000);
      sb_check("minute_carry", time_bcd);
      press_start;

      // Hour carry below the limit, and wrap at a 12-hour limit
      load_preset(32'h1259_5999);
      press_start;
      cyc(9);
      exp_q.push_back(32'h1300_0000);
      sb_check("hour_carry_99", time_bcd);
      exp_q.push_back(32'h0000_0000);
      sb_check("hour_wrap_12", time12);
      check_eq("wrap12_running", {31'd0, running12}, 32'd1);
      press_start;

      // Wrap at 99 hours keeps running
      load_preset(32'h9959_5999);
      press_start;
      cyc(9);
      exp_q.push_back(32'h0000_0000);
      sb_check("hour_wrap_99", time_bcd);
      check_eq("wrap99_running", {31'd0, running}, 32'd1);
      press_start;

      // Per-digit clamp of an invalid preset
      load_preset(32'hFA6B_7CDE);
      exp_q.push_back(32'h9959_5999);
      sb_check("preset_clamp", time_bcd);

      // Lap hold while running
      load_preset(32'h0000_0240);
      press_start;
      cyc(99);
      press_lap;
      check_eq("lap_active_on", {31'd0, lap_active}, 32'd1);
      exp_q.push_back(32'h0000_0250);
      sb_check("lap_frozen", disp_bcd);
      cyc(49);
      exp_q.push_back(32'h0000_0255);
      sb_check("time_moves_in_lap", time_bcd);
      exp_q.push_back(32'h0000_0250);
      sb_check("lap_still_frozen", disp_bcd);
      press_lap;
      check_eq("lap_active_off", {31'd0, lap_active}, 32'd0);
      exp_q.push_back(32'h0000_0255);
      sb_check("disp_tracks", disp_bcd);
      press_lap;
      press_start;
      check_eq("stop_clears_lap", {31'd0, lap_active}, 32'd0);
      exp_q.push_back(32'h0000_0255);
      sb_check("disp_after_stop", disp_bcd);

      // Stopped lap clears; stop/resume keeps prescaler phase
      press_lap;
      exp_q.push_back(32'h0000_0000);
      sb_check("stopped_clear", time_bcd);
      press_start;
      cyc(4);
      press_start;
      cyc(20);
      exp_q.push_back(32'h0000_0000);
      sb_check("held_while_stopped", time_bcd);
      press_start;
      cyc(2);
      check_eq("resume_no_tick_yet", {31'd0, tick}, 32'd0);
      cyc(1);
      check_eq("resume_tick", {31'd0, tick}, 32'd1);
      cyc(1);
      exp_q.push_back(32'h0000_0001);
      sb_check("resume_advance", time_bcd);
      press_start;

      // Start and lap edges together while stopped: start wins, no clear
      start = 1'b1;
      lap = 1'b1;
      cyc(1);
      start = 1'b0;
      lap = 1'b0;
      cyc(1);
      check_eq("both_running", {31'd0, running}, 32'd1);
      check_eq("both_lap_active", {31'd0, lap_active}, 32'd0);
      exp_q.push_back(32'h0000_0001);
      sb_check("both_no_clear", time_bcd);

      // Load ignored while running
      load_preset(32'h1234_5678);
      exp_q.push_back(32'h0000_0001);
      sb_check("load_ignored_running", time_bcd);
      press_start;

      // Load together with a start edge while stopped
      preset = 32'h0000_0500;
      load = 1'b1;
      start = 1'b1;
      cyc(1);
      load = 1'b0;
      start = 1'b0;
      cyc(1);
      check_eq("load_start_running", {31'd0, running}, 32'd1);
      exp_q.push_back(32'h0000_0500);
      sb_check("load_start_time", time_bcd);

      // Reset mid-run with start held high
      reset = 1'b1;
      start = 1'b1;
      cyc(3);
      exp_q.push_back(32'h0000_0000);
      sb_check("midreset_time", time_bcd);
      check_eq("midreset_running", {31'd0, running}, 32'd0);
      reset = 1'b0;
      cyc(30);
      check_eq("held_start_no_run", {31'd0, running}, 32'd0);
      exp_q.push_back(32'h0000_0000);
      sb_check("held_start_time", time_bcd);
      start = 1'b0;
      cyc(1);
      press_start;
      check_eq("new_edge_runs", {31'd0, running}, 32'd1);
      press_start;

`ifdef COUNTDOWN_EN
      // Count down to zero: single done pulse, then stop
      mode_down = 1'b1;
      load_preset(32'h0000_0003);
      press_start;
      cyc(28);
      exp_q.push_back(32'h0000_0001);
      sb_check("down_two_ticks", time_bcd);
      check_eq("down_done_early", {31'd0, done}, 32'd0);
      cyc(1);
      exp_q.push_back(32'h0000_0000);
      sb_check("down_zero", time_bcd);
      check_eq("down_done_pulse", {31'd0, done}, 32'd1);
      check_eq("down_stopped", {31'd0, running}, 32'd0);
      cyc(1);
      check_eq("down_done_single", {31'd0, done}, 32'd0);
      press_start;
      check_eq("down_zero_no_start", {31'd0, running}, 32'd0);
      mode_down = 1'b0;
`else
      // Without countdown support mode_down is ignored
      mode_down = 1'b1;
      load_preset(32'h0000_0003);
      press_start;
      cyc(9);
      exp_q.push_back(32'h0000_0004);
      sb_check("mode_down_ignored", time_bcd);
      check_eq("done_tied_low", {31'd0, done}, 32'd0);
      press_start;
      mode_down = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lap_stopwatch_core.md
Name: lap_stopwatch_core

Overview:
Parametrised stopwatch timing core for the clock board: prescales clk to a hundredths tick and runs an 8-digit packed-BCD time HH:MM:SS.cc. Adds lap-hold, clear, preset load and a configurable hour limit. Its 32-bit BCD outputs drive the existing digit-scan and BCD-to-segment display path; start and lap are level inputs from already-debounced buttons.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 100, count rate in Hz (one LSB of cc); DIV = CLK_HZ/TICK_HZ, must be >= 2
MAX_HOURS, 99, hour value after which count-up wraps to 00:00:00.00 (1..99)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  start/stop button level; rising edge toggles run
lap  in  1  lap button level; rising edge = lap toggle (running) or clear (stopped)
mode_down  in  1  1 = count down; used only with COUNTDOWN_EN
load  in  1  1-cycle pulse: load preset into time (accepted only when stopped)
preset  in  32  packed-BCD load value, same layout as time_bcd
time_bcd  out  32  live time; [31:28] H tens ... [7:4] cc tens, [3:0] cc ones
disp_bcd  out  32  display value: time_bcd, or frozen lap value while lap_active
running  out  1  1 while counting
lap_active  out  1  1 while display frozen
tick  out  1  1-cycle pulse on each count advance
done  out  1  1-cycle pulse when countdown reaches zero (COUNTDOWN_EN only, else 0)

Behaviour:
- Reset (clk edge with reset=1): time=0, lap register=0, prescaler=0, running=0, lap_active=0, tick=0, done=0, edge-detect registers loaded with current start/lap levels (no spurious edge after reset).
- Edge detect: one register stage per button; edge = level & ~prev; action takes effect at that clock edge.
- States: STOPPED, RUNNING (running output = state).
- STOPPED: start edge -> RUNNING. lap edge -> time=0, lap_active=0, prescaler=0. load -> time=preset, prescaler=0. Prescaler holds.
- RUNNING: start edge -> STOPPED, prescaler holds its value (resume keeps phase). lap edge -> if lap_active=0: lap register=time_bcd, lap_active=1; else lap_active=0. load ignored.
- Prescaler counts 0..DIV-1 in RUNNING; at DIV-1 -> 0, tick=1 same cycle, time advances one LSB (registered; new time visible next cycle). First tick DIV cycles after start from prescaler 0.
- Count-up carries: cc 99->00 carry; SS 59->00 carry; MM 59->00 carry; HH == MAX_HOURS with carry -> 00:00:00.00 (wrap, keeps running, no done).
- Each BCD digit in 0..9; tens of SS/MM in 0..5. Preset with invalid digits: each digit >9 is loaded as 9 and SS/MM tens >5 as 5 (clamp per digit).
- Simultaneous start and lap edges same cycle: start handled, lap ignored. load with start edge while STOPPED: load applied and transition to RUNNING.
- disp_bcd = lap_active ? lap register : time_bcd (combinational mux of registers).
- lap_active forced 0 on any transition to STOPPED.

Optional Feature:
Macro COUNTDOWN_EN. Defined: mode_down=1 makes each tick decrement (borrows mirror carries; HH 00 borrow not reached). When time reaches 00:00:00.00 during countdown: done=1 for one cycle, state -> STOPPED, time stays 0. Start edge at time=0 with mode_down=1: stays STOPPED. mode_down sampled each tick. Not defined: mode_down ignored, done tied 0, count-up only.

Test Plan:
CLK_HZ=1000, TICK_HZ=100: reset, start edge, run 10000 cycles -> time_bcd=32'h0000_1000 (10.00 s), tick pulses every 10 cycles.
Preset 32'h0000_5999 load, start, 1 tick -> 32'h0001_0000; preset 32'h9959_5999, MAX_HOURS=99, 1 tick -> 32'h0000_0000, running stays 1.
Running, lap edge at 32'h0000_0250 -> disp_bcd frozen 32'h0000_0250 while time_bcd advances; second lap edge -> disp_bcd tracks time_bcd; stop -> lap_active=0.
Stop at 5 prescaler counts, resume -> next tick 5 cycles later; stopped lap edge -> time 0; start and lap edge same cycle -> RUNNING, lap_active=0.
COUNTDOWN_EN, preset 32'h0000_0003, mode_down=1, start -> after 3 ticks time=0, done single pulse, running=0; start edge again -> remains stopped.
Reset asserted mid-run with start held high -> all outputs 0, no run after reset deasserts until a new start rising edge.
